mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Arbitrates instruction fetch and data accesses onto a single RAM port
//          with retry on ERROR, per-access timeout and a saturating error count.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        timeout,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] C_RAM_ACCESS = 2'd2;
    localparam logic [1:0] C_RAM_ERROR  = 2'd3;
    localparam logic [7:0] C_WAIT_LAST  = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DBUSY = 3'd1,
        S_IBUSY = 3'd2,
        S_DRESP = 3'd3,
        S_IRESP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        wr_q, wr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            store_q   <= '0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Data side always wins; a pending fetch waits for the next IDLE.
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    store_d = dWEN ? dstore : '0;
                    wr_d    = dWEN;
                    cnt_d   = '0;
                    state_d = S_DBUSY;
                end else if (iREN) begin
                    addr_d  = iaddr;
                    store_d = '0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IBUSY;
                end
            end

            S_DBUSY, S_IBUSY: begin
                ramREN   = ~wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                if (ramstate == C_RAM_ACCESS) begin
                    if (state_q == S_IBUSY) begin
                        iload_d = ramload;
                        state_d = S_IRESP;
                    end else begin
                        if (!wr_q) begin
                            dload_d = ramload;
                        end
                        state_d = S_DRESP;
                    end
                end else if (ramstate == C_RAM_ERROR) begin
                    // Back to IDLE so the still-held request is re-arbitrated.
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == C_WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DRESP: begin
                dhit    = 1'b1;
                state_d = S_IDLE;
            end

            S_IRESP: begin
                ihit    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iload   = iload_q;
    assign dload   = dload_q;
    assign timeout = timeout_q;
    assign err_cnt = err_q;

endmodule

`default_nettype wire
